// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-add stages; purely combinational.
module fa_cell (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic carry_out
);

  logic ha1_sum_s;
  logic ha1_carry_s;
  logic ha2_carry_s;

  assign ha1_sum_s   = a_in ^ b_in;
  assign ha1_carry_s = a_in & b_in;
  assign sum_out     = ha1_sum_s ^ c_in;
  assign ha2_carry_s = ha1_sum_s & c_in;
  assign carry_out   = ha1_carry_s | ha2_carry_s;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: operands shift LSB-first through a single fa_cell, one bit per clock.
// Status and result outputs are registered from the state, so they trail the FSM by one cycle.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_sum_s;
  logic fa_carry_s;

  fa_cell u_fa (
    .a_in      (a_q[0]),
    .b_in      (b_q[0]),
    .c_in      (carry_q),
    .sum_out   (fa_sum_s),
    .carry_out (fa_carry_s)
  );

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_SHIFT;
          a_d     = a_in;
          b_d     = b_in;
          psum_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        busy_d  = 1'b1;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        psum_d  = {fa_sum_s, psum_q[WIDTH-1:1]};
        carry_d = fa_carry_s;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Publish the finished result; a waiting start restarts immediately.
        done_d = 1'b1;
        sum_d  = psum_q;
        cout_d = carry_q;
        if (start_in) begin
          state_d = ST_SHIFT;
          a_d     = a_in;
          b_d     = b_in;
          psum_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign sum_out   = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed cases plus randomized
// operands against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W       = 8;
  localparam int EXP_LAT = W + 1;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         start_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] sum_out;
  logic         carry_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] prev_s = '0;
  logic         prev_c = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .start_in  (start_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  always #5 clk_in = ~clk_in;

  // Result must not move while an addition is in progress
  a_sum_hold: assert property (@(posedge clk_in) disable iff (!rst_n_in)
                               busy_out |-> ($stable(sum_out) && $stable(carry_out)))
    else $error("FAIL sum_hold_assert sum=%h carry=%b", sum_out, carry_out);

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Present start with operands on a falling edge; return just after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk_in);
    start_in = 1'b1;
    a_in     = a;
    b_in     = b;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
  endtask

  // Count edges until done_out is seen (bounded); tally busy cycles and result disturbances.
  task automatic wait_done(input logic [W-1:0] ps, input logic pc,
                           output int lat, output int busy_cnt, output int hold_bad);
    lat      = -1;
    busy_cnt = 0;
    hold_bad = 0;
    for (int e = 1; e <= 3 * W; e++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (busy_out) busy_cnt++;
      if (done_out) begin
        lat = e;
        break;
      end
      if (sum_out !== ps || carry_out !== pc) hold_bad++;
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    #2;
    n_cmp++;
    if ({busy_out, done_out, sum_out, carry_out} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h c=%b want all 0",
               busy_out, done_out, sum_out, carry_out);
    end
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (busy_out !== 1'b0 || done_out !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy_out, done_out);
    end
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_s, input logic exp_c);
    int lat, bc, hb;
    start_op(a, b);
    wait_done(prev_s, prev_c, lat, bc, hb);
    n_cmp++;
    if (lat !== EXP_LAT) begin
      n_bad++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, EXP_LAT);
    end
    n_cmp++;
    if (sum_out !== exp_s || carry_out !== exp_c) begin
      n_bad++;
      $display("FAIL %s_result got %h/%b want %h/%b", name, sum_out, carry_out, exp_s, exp_c);
    end
    n_cmp++;
    if (bc !== W) begin
      n_bad++;
      $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, W);
    end
    n_cmp++;
    if (hb !== 0) begin
      n_bad++;
      $display("FAIL %s_hold got %0d disturbed cycles want 0", name, hb);
    end
    @(negedge clk_in);
    n_cmp++;
    if (done_out !== 1'b0 || busy_out !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done_pulse got done=%b busy=%b want 0 0", name, done_out, busy_out);
    end
    prev_s = exp_s;
    prev_c = exp_c;
  endtask

  task automatic test_back_to_back();
    int lat, bc, hb;
    @(negedge clk_in);
    start_in = 1'b1;
    a_in     = 8'hFF;
    b_in     = 8'hFF;
    @(posedge clk_in);
    #1;
    a_in = 8'h11;
    b_in = 8'h11;
    wait_done(prev_s, prev_c, lat, bc, hb);
    start_in = 1'b0;
    n_cmp++;
    if (lat !== EXP_LAT || sum_out !== 8'hFE || carry_out !== 1'b1 || bc !== W) begin
      n_bad++;
      $display("FAIL b2b_first got lat=%0d sum=%h c=%b busy=%0d want %0d FE 1 %0d",
               lat, sum_out, carry_out, bc, EXP_LAT, W);
    end
    wait_done(8'hFE, 1'b1, lat, bc, hb);
    n_cmp++;
    if (lat !== EXP_LAT || sum_out !== 8'h22 || carry_out !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second got lat=%0d sum=%h c=%b want %0d 22 0",
               lat, sum_out, carry_out, EXP_LAT);
    end
    n_cmp++;
    if (bc !== W || hb !== 0) begin
      n_bad++;
      $display("FAIL b2b_second_busy got busy=%0d hold_bad=%0d want %0d 0", bc, hb, W);
    end
    prev_s = 8'h22;
    prev_c = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, hb;
    int done_seen;
    test_directed("pre_abort", 8'h5A, 8'h3C, 8'h96, 1'b0);
    start_op(8'h01, 8'h01);
    repeat (3) begin
      @(posedge clk_in);
      @(negedge clk_in);
    end
    n_cmp++;
    if (busy_out !== 1'b1 || sum_out !== 8'h96) begin
      n_bad++;
      $display("FAIL abort_pre got busy=%b sum=%h want 1 96", busy_out, sum_out);
    end
    rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if ({busy_out, done_out, sum_out, carry_out} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_outputs got busy=%b done=%b sum=%h c=%b want all 0",
               busy_out, done_out, sum_out, carry_out);
    end
    done_seen = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (done_out) done_seen++;
    end
    // Release and immediately request: must be taken on the first edge out of reset.
    rst_n_in = 1'b1;
    start_in = 1'b1;
    a_in     = 8'h80;
    b_in     = 8'h80;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    wait_done(8'h00, 1'b0, lat, bc, hb);
    n_cmp++;
    if (done_seen !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done got %0d done pulses want 0", done_seen);
    end
    n_cmp++;
    if (lat !== EXP_LAT || sum_out !== 8'h00 || carry_out !== 1'b1) begin
      n_bad++;
      $display("FAIL after_release got lat=%0d sum=%h c=%b want %0d 00 1",
               lat, sum_out, carry_out, EXP_LAT);
    end
    prev_s = 8'h00;
    prev_c = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_random();
    int lat, bc, hb;
    logic [W-1:0] a, b;
    logic [W:0]   exp;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
      a   = W'($urandom);
      b   = W'($urandom);
      exp = ref_add(a, b);
      start_op(a, b);
      wait_done(prev_s, prev_c, lat, bc, hb);
      n_cmp++;
      if (lat !== EXP_LAT || bc !== W || hb !== 0) begin
        n_bad++;
        $display("FAIL rand%0d_timing got lat=%0d busy=%0d hold_bad=%0d want %0d %0d 0",
                 i, lat, bc, hb, EXP_LAT, W);
      end
      n_cmp++;
      if (sum_out !== exp[W-1:0] || carry_out !== exp[W]) begin
        n_bad++;
        $display("FAIL rand%0d_result %h+%h got %h/%b want %h/%b",
                 i, a, b, sum_out, carry_out, exp[W-1:0], exp[W]);
      end
      prev_s = exp[W-1:0];
      prev_c = exp[W];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed("add_5a_3c", 8'h5A, 8'h3C, 8'h96, 1'b0);
    test_directed("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have one clock; reset is asynchronous and active-low: clk_in  input  1  rising-edge clock.
REQ-003 SHALL have rst_n_in  input  1  asynchronous active-low reset.
REQ-004 SHALL have start_in  input  1  request to add a_in and b_in, sampled on rising clk_in.
REQ-005 SHALL have a_in  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 SHALL have b_in  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 SHALL have busy_out  output  1  high while an addition is in progress.
REQ-008 SHALL have done_out  output  1  one-cycle pulse when the result is valid.
REQ-009 SHALL have sum_out  output  WIDTH  registered result of a_in+b_in modulo 2^WIDTH.
REQ-010 SHALL have carry_out  output  1  registered carry out of the MSB.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start_in=1: SHALL latch a_in/b_in into shift registers, clear internal carry, clear bit counter, and go to SHIFT.
REQ-013 In SHIFT, each cycle SHALL add operand LSBs plus internal carry through one 1-bit full-add cell.
REQ-014 In SHIFT, each cycle SHALL shift the sum bit into the MSB of the partial-sum register, shift both operands right by one, and increment the counter.
REQ-015 SHALL spend exactly WIDTH cycles in SHIFT, then go to DONE.
REQ-016 Counter width SHALL be clog2(WIDTH+1); no wrap is permitted before DONE.
REQ-017 On entry to DONE, sum_out and carry_out SHALL be loaded from the partial-sum register and the final carry.
REQ-018 done_out SHALL be high for exactly the one DONE cycle; busy_out SHALL be high in SHIFT only.
REQ-019 Latency: if start is accepted at edge 0, done_out SHALL be high in the cycle following edge WIDTH+1; this is 9 edges for WIDTH=8.
REQ-020 In DONE with start_in=1: start SHALL be accepted exactly as in IDLE, going to SHIFT (back-to-back throughput).
REQ-021 In DONE with start_in=0: SHALL return to IDLE.
REQ-022 start_in SHALL be ignored while in SHIFT; operands SHALL not change mid-operation.
REQ-023 sum_out and carry_out SHALL hold their last result until the next DONE entry and SHALL not toggle during SHIFT.
REQ-024 Unused FSM encodings SHALL recover to IDLE on the next clock.

Reset
REQ-025 rst_n_in low SHALL asynchronously force IDLE and clear the counter, shift registers, and internal carry.
REQ-026 rst_n_in low SHALL asynchronously force busy_out=0, done_out=0, sum_out=0, carry_out=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done_out pulse.
REQ-028 After release, the first start_in SHALL be accepted on the first rising edge where rst_n_in is high.

Structure
REQ-029 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and DEFAULT_WIDTH=8 SHALL live in shared package serial_adder_pkg.
REQ-030 The 1-bit adder SHALL be sub-module fa_cell (inputs a_in, b_in, c_in; outputs sum_out, carry_out).
REQ-031 fa_cell SHALL be built from two half-add stages plus an OR of their carries; it SHALL be the only arithmetic in the block.
REQ-032 All sequential logic SHALL be in serial_adder_ctrl; fa_cell SHALL be purely combinational.

Verification (WIDTH=8)
REQ-033 start with a=0x5A, b=0x3C -> done_out pulses 9 edges later; sum_out=0x96, carry_out=0.
REQ-034 start with a=0xFF, b=0x01 -> sum_out=0x00, carry_out=1; busy_out high for exactly 8 cycles.
REQ-035 start 0xFF+0xFF, then start_in held high through SHIFT with a_in=0x11 -> first result sum_out=0xFE, carry_out=1.
REQ-036 Continuing REQ-035: start held in DONE is accepted back-to-back with a_in=0x11, b_in=0x11 -> second done_out gives 0x22, carry_out=0.
REQ-037 Result 0x96 held, start 0x01+0x01, rst_n_in low at SHIFT cycle 4 -> no done_out; all outputs 0 immediately.
REQ-038 Continuing REQ-037: after release, start 0x80+0x80 -> sum_out=0x00, carry_out=1.
REQ-039 During any SHIFT, sum_out/carry_out remain equal to the previous result every cycle (checked by assertion).
